oled_spi_sniffer: RTL and testbench
===================================

# oled_spi_sniffer

Passive SPI receiver for the PmodOLED bus. It observes the CS/SCLK/SDIN/DC lines that the OLED controller drives and deframes them into command and data bytes. It tracks the SSD1306 page-addressing pointers and mirrors every display data byte into a local PAGES×COLS framebuffer. The framebuffer has a synchronous read port, so the UART/FIFO side of the design can read the panel contents back for self-checking and debug.

## Interface
Parameters:
- PAGES, 4, display pages; power of two, 1..8
- COLS, 128, columns per page; fixed at 128 (7-bit column pointer)

Ports:
- CLK  in  1  system clock, 100 MHz
- RST  in  1  reset; synchronous, active-high; clock CLK
- CS  in  1  SPI chip select, active-low, asynchronous to CLK
- SCLK  in  1  SPI clock, idles high; data sampled on rising edge (mode 3)
- SDIN  in  1  SPI data, MSB first
- DC  in  1  0 = command byte, 1 = display data byte
- byte_valid  out  1  one-cycle pulse per received byte
- byte_data  out  8  received byte, held until next byte_valid
- byte_is_data  out  1  DC captured with the byte, held with byte_data
- cur_page  out  $clog2(PAGES)  current page pointer
- cur_col  out  7  current column pointer
- frame_err  out  1  sticky; set when CS deasserts mid-byte
- data_count  out  16  count of data bytes, saturates at 0xFFFF
- fb_rd_addr  in  $clog2(PAGES*COLS)  read address, page*128+col
- fb_rd_data  out  8  framebuffer read data

## Operation
- **Input synchronisation:** CS, SCLK, SDIN and DC each pass through a 2-flop synchroniser. A rising edge of SCLK is detected on the synchronised signal against a registered copy.
- **Shift register:**
  - Runs only while synchronised CS = 0.
  - On each SCLK rise: shift in SDIN and increment a 3-bit bit counter.
  - On the 8th rise, DC is captured along with the byte.
- **Deassert/abort:**
  - CS high clears the bit counter.
  - If the bit counter is nonzero when CS goes high, frame_err is set and the partial byte is discarded with no byte_valid.
- **Data byte (DC = 1):**
  - Write fb[cur_page*128+cur_col].
  - cur_col increments and wraps 127→0. cur_page does not change (page addressing mode).
  - data_count increments, saturating.
- **Command decoder, state CMD_IDLE:**
  - 0x00–0x0F: cur_col[3:0] = cmd[3:0].
  - 0x10–0x17: cur_col[6:4] = cmd[2:0].
  - 0xB0–0xB7: cur_page = cmd[2:0] modulo PAGES.
  - 0x81, 0x8D, 0xA8, 0xD3, 0xD5, 0xD9, 0xDA, 0xDB, 0x20: go to CMD_ARG with skip = 1.
  - 0x21, 0x22: go to CMD_ARG with skip = 2.
  - All other commands are ignored.
- **Command decoder, state CMD_ARG:**
  - Each command byte decrements skip. The byte is not decoded.
  - Return to CMD_IDLE when skip reaches 0.
  - A data byte in CMD_ARG aborts to CMD_IDLE and is then processed as a normal data byte.
- **Framebuffer:**
  - Inferred block RAM, read-first.
  - Contents are not cleared by RST.
- **Reset:** all outputs and internal state reset to 0: byte_valid, byte_data, byte_is_data, cur_page, cur_col, frame_err, data_count, fb_rd_data, bit counter, command state, skip. Asserting RST mid-byte discards the partial byte.

## Timing
- byte_valid rises exactly 4 CLK cycles after the 8th SCLK rising edge appears at the pin: 2 sync stages, 1 edge register, 1 output register.
- The framebuffer write, pointer update and data_count update all occur on the same edge that asserts byte_valid.
- cur_page and cur_col are visible the cycle after byte_valid.
- Read latency is 1 cycle: fb_rd_addr sampled at edge k produces fb_rd_data after edge k.
- Simultaneous read and write to the same address returns the old data.
- The SCLK high and low phases must each be ≥ 2 CLK periods (SCLK ≤ CLK/4).
- A CS deassert must follow the last SCLK rise by ≥ 2 CLK periods.

## Configuration
- Macro: OLED_SNIFF_FB_EN.
- **Defined:** framebuffer, fb_rd_addr and fb_rd_data are functional as described above.
- **Undefined:**
  - No RAM is inferred.
  - fb_rd_data is tied to 0 and fb_rd_addr is ignored.
  - Byte stream, pointers, frame_err and data_count are unchanged.

## Test plan
- **Addressing and write:** CS low; send 0xB2, 0x05, 0x13 with DC = 0, then 0xA5 with DC = 1.
  - Expect 4 byte_valid pulses with byte_is_data 0, 0, 0, 1.
  - Final cur_page = 2, cur_col = 0x36.
  - Read of address 309 returns 0xA5 one cycle after the address is applied.
- **Column wrap:** set page 1, column 127; send data 0x11, 0x22.
  - fb[255] = 0x11, fb[128] = 0x22.
  - cur_col = 1, cur_page = 1.
- **Argument skip:** send 0x81, 0xB5, then 0x21, 0xB3, 0x07 (all DC = 0).
  - cur_page and cur_col unchanged.
  - Command state returns to CMD_IDLE.
  - 5 byte_valid pulses.
- **Framing error:** 5 SCLK bits, then CS high.
  - No byte_valid; frame_err = 1.
  - After CS low again, byte 0x3C is received intact; frame_err stays 1.
- **Reset mid-byte:** RST after 3 bits.
  - All outputs read 0.
  - After RST drops, a full 8-bit 0xC3 produces byte_data = 0xC3.
- **Data-count saturation:** preset the count via 65,537 data bytes.
  - data_count = 0xFFFF.
  - With OLED_SNIFF_FB_EN undefined, fb_rd_data stays 0 throughout.

Source files
------------

// File: rtl/oled_spi_sniffer.sv
// oled_spi_sniffer: passive PmodOLED SPI receiver.
// Deframes CS/SCLK/SDIN/DC into command/data bytes, tracks the SSD1306
// page-addressing pointers and mirrors display data into a PAGES x 128
// framebuffer with a one-cycle synchronous read port.
// Build option: define OLED_SNIFF_FB_EN to include the framebuffer RAM;
// without it fb_rd_data reads 0 and fb_rd_addr is ignored.
module oled_spi_sniffer #(
  parameter int PAGES = 4,
  parameter int COLS = 128,
  localparam int PAGE_W = (PAGES > 1) ? $clog2(PAGES) : 1,
  localparam int ADDR_W = $clog2(PAGES * COLS)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CS,
  input  logic              SCLK,
  input  logic              SDIN,
  input  logic              DC,
  output logic              byte_valid,
  output logic [7:0]        byte_data,
  output logic              byte_is_data,
  output logic [PAGE_W-1:0] cur_page,
  output logic [6:0]        cur_col,
  output logic              frame_err,
  output logic [15:0]       data_count,
  input  logic [ADDR_W-1:0] fb_rd_addr,
  output logic [7:0]        fb_rd_data
);

  typedef enum logic {
    CMD_IDLE = 1'b0,
    CMD_ARG  = 1'b1
  } cmd_state_t;

  // Synchroniser lanes: 3 = CS, 2 = SCLK, 1 = SDIN, 0 = DC.
  // CS and SCLK reset to their idle-high level so no false edge follows reset.
  localparam logic [3:0] SYNC_IDLE = 4'b1100;

  logic [3:0] pin_vec;
  logic [3:0] sync1_reg;
  logic [3:0] sync2_reg;
  logic       sclk_prev_reg;
  logic       cs_s;
  logic       sclk_s;
  logic       sdin_s;
  logic       dc_s;
  logic       sclk_rise;

  // Deframer state
  logic [2:0] bit_cnt_reg;
  logic [7:0] shift_reg;
  logic       byte_done_reg;
  logic       dc_cap_reg;

  // Command decoder / pointer state
  cmd_state_t          state_reg;
  cmd_state_t          state_next;
  logic [1:0]          skip_reg;
  logic [1:0]          skip_next;
  logic [PAGE_W-1:0]   page_reg;
  logic [PAGE_W-1:0]   page_next;
  logic [PAGE_W-1:0]   page_from_cmd;
  logic [6:0]          col_reg;
  logic [6:0]          col_next;
  logic [15:0]         count_reg;
  logic [15:0]         count_next;
  logic                fb_we;
  logic [ADDR_W-1:0]   fb_wr_addr;

  assign pin_vec = {CS, SCLK, SDIN, DC};

  // Two-flop synchroniser per asynchronous pin, one lane per input.
  for (genvar gi = 0; gi < 4; gi++) begin : g_sync
    always_ff @(posedge CLK) begin
      if (RST) begin
        sync1_reg[gi] <= SYNC_IDLE[gi];
        sync2_reg[gi] <= SYNC_IDLE[gi];
      end else begin
        sync1_reg[gi] <= pin_vec[gi];
        sync2_reg[gi] <= sync1_reg[gi];
      end
    end
  end

  assign cs_s   = sync2_reg[3];
  assign sclk_s = sync2_reg[2];
  assign sdin_s = sync2_reg[1];
  assign dc_s   = sync2_reg[0];

  // Registered copy of synchronised SCLK for rising-edge detection.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sclk_prev_reg <= 1'b1;
    end else begin
      sclk_prev_reg <= sclk_s;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_prev_reg;

  // Shift in bits while selected; abort a partial byte when CS rises.
  always_ff @(posedge CLK) begin
    if (RST) begin
      bit_cnt_reg   <= 3'd0;
      shift_reg     <= 8'h00;
      byte_done_reg <= 1'b0;
      dc_cap_reg    <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      byte_done_reg <= 1'b0;
      if (cs_s) begin
        bit_cnt_reg <= 3'd0;
        if (bit_cnt_reg != 3'd0) begin
          frame_err <= 1'b1;
        end
      end else if (sclk_rise) begin
        shift_reg   <= {shift_reg[6:0], sdin_s};
        bit_cnt_reg <= bit_cnt_reg + 3'd1;
        if (bit_cnt_reg == 3'd7) begin
          byte_done_reg <= 1'b1;
          dc_cap_reg    <= dc_s;
        end
      end
    end
  end

  // Page number taken from a 0xB0..0xB7 command, folded into the page range.
  assign page_from_cmd = PAGE_W'(shift_reg[2:0] & 3'(PAGES - 1));

  // Decode each completed byte: data writes and advances, commands move pointers.
  always_comb begin
    state_next = state_reg;
    skip_next  = skip_reg;
    page_next  = page_reg;
    col_next   = col_reg;
    count_next = count_reg;
    fb_we      = 1'b0;
    fb_wr_addr = ADDR_W'({page_reg, col_reg});
    if (byte_done_reg) begin
      if (dc_cap_reg) begin
        // Data always lands in the buffer, even if it interrupts an argument list.
        state_next = CMD_IDLE;
        skip_next  = 2'd0;
        fb_we      = 1'b1;
        col_next   = col_reg + 7'd1;
        if (count_reg != 16'hFFFF) begin
          count_next = count_reg + 16'd1;
        end
      end else if (state_reg == CMD_ARG) begin
        // Argument bytes are swallowed without decoding.
        skip_next = skip_reg - 2'd1;
        if (skip_reg == 2'd1) begin
          state_next = CMD_IDLE;
        end
      end else begin
        case (shift_reg) inside
          [8'h00:8'h0F]: col_next = {col_reg[6:4], shift_reg[3:0]};
          [8'h10:8'h17]: col_next = {shift_reg[2:0], col_reg[3:0]};
          [8'hB0:8'hB7]: page_next = page_from_cmd;
          8'h81, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB, 8'h20: begin
            state_next = CMD_ARG;
            skip_next  = 2'd1;
          end
          8'h21, 8'h22: begin
            state_next = CMD_ARG;
            skip_next  = 2'd2;
          end
          default: ;
        endcase
      end
    end
  end

  // Decoder state, pointers and data counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= CMD_IDLE;
      skip_reg  <= 2'd0;
      page_reg  <= '0;
      col_reg   <= 7'd0;
      count_reg <= 16'd0;
    end else begin
      state_reg <= state_next;
      skip_reg  <= skip_next;
      page_reg  <= page_next;
      col_reg   <= col_next;
      count_reg <= count_next;
    end
  end

  // Byte output stage: one-cycle strobe, data and DC held until the next byte.
  always_ff @(posedge CLK) begin
    if (RST) begin
      byte_valid   <= 1'b0;
      byte_data    <= 8'h00;
      byte_is_data <= 1'b0;
    end else begin
      byte_valid <= byte_done_reg;
      if (byte_done_reg) begin
        byte_data    <= shift_reg;
        byte_is_data <= dc_cap_reg;
      end
    end
  end

  assign cur_page   = page_reg;
  assign cur_col    = col_reg;
  assign data_count = count_reg;

`ifdef OLED_SNIFF_FB_EN
  logic [7:0] fb_mem [PAGES * COLS];
  logic [7:0] fb_rd_reg;

  // Framebuffer write port; contents survive reset.
  always_ff @(posedge CLK) begin
    if (fb_we) begin
      fb_mem[fb_wr_addr] <= shift_reg;
    end
  end

  // Registered read port; same-address write returns the old contents.
  always_ff @(posedge CLK) begin
    if (RST) begin
      fb_rd_reg <= 8'h00;
    end else begin
      fb_rd_reg <= fb_mem[fb_rd_addr];
    end
  end

  assign fb_rd_data = fb_rd_reg;
`else
  logic unused_fb;
  assign unused_fb  = ^{fb_rd_addr, fb_wr_addr, fb_we};
  assign fb_rd_data = 8'h00;
`endif

endmodule

// File: tb/tb_oled_spi_sniffer.sv
// Testbench for oled_spi_sniffer: directed and randomised SPI traffic
// checked against a byte-level model of the OLED command/data rules.
module tb_oled_spi_sniffer;
  localparam int PAGES = 4;
  localparam int COLS = 128;
  localparam int PAGE_W = 2;
  localparam int ADDR_W = $clog2(PAGES * COLS);
`ifdef OLED_SNIFF_FB_EN
  localparam bit FB_EN = 1'b1;
`else
  localparam bit FB_EN = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              RST;
  logic              CS;
  logic              SCLK;
  logic              SDIN;
  logic              DC;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_is_data;
  logic [PAGE_W-1:0] cur_page;
  logic [6:0]        cur_col;
  logic              frame_err;
  logic [15:0]       data_count;
  logic [ADDR_W-1:0] fb_rd_addr;
  logic [7:0]        fb_rd_data;

  oled_spi_sniffer #(.PAGES(PAGES), .COLS(COLS)) dut (
    .CLK(CLK), .RST(RST), .CS(CS), .SCLK(SCLK), .SDIN(SDIN), .DC(DC),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_is_data(byte_is_data),
    .cur_page(cur_page), .cur_col(cur_col), .frame_err(frame_err),
    .data_count(data_count), .fb_rd_addr(fb_rd_addr), .fb_rd_data(fb_rd_data)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  int pulse_cnt = 0;

  // Reference model state
  int         m_page = 0;
  int         m_col = 0;
  int         m_count = 0;
  int         m_skip = 0;
  int         m_err = 0;
  int         m_pulses = 0;
  logic [7:0] m_fb [PAGES * COLS];
  int         wr_q[$];

  logic [7:0] arg_cmds [11] = '{8'h81, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9,
                                8'hDA, 8'hDB, 8'h20, 8'h21, 8'h22};

  // Count every strobe the DUT emits, sampled mid-cycle.
  always @(negedge CLK) begin
    if (byte_valid === 1'b1) pulse_cnt <= pulse_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] fb_exp(input int addr);
    return FB_EN ? m_fb[addr] : 8'h00;
  endfunction

  // Apply one received byte to the model using the OLED rules directly.
  task automatic model_byte(input logic [7:0] b, input logic dc);
    int v = int'(b);
    m_pulses++;
    if (dc) begin
      m_skip = 0;
      m_fb[m_page * COLS + m_col] = b;
      wr_q.push_back(m_page * COLS + m_col);
      m_col = (m_col + 1) % COLS;
      if (m_count < 65535) m_count++;
    end else if (m_skip > 0) begin
      m_skip--;
    end else if (v <= 15) begin
      m_col = (m_col / 16) * 16 + v % 16;
    end else if (v <= 23) begin
      m_col = (v % 8) * 16 + m_col % 16;
    end else if (v >= 'hB0 && v <= 'hB7) begin
      m_page = (v % 8) % PAGES;
    end else if (v == 'h21 || v == 'h22) begin
      m_skip = 2;
    end else if (v == 'h81 || v == 'h8D || v == 'hA8 || v == 'hD3 || v == 'hD5 ||
                 v == 'hD9 || v == 'hDA || v == 'hDB || v == 'h20) begin
      m_skip = 1;
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge CLK);
    SCLK = 1'b0;
    SDIN = b;
    repeat (2) @(negedge CLK);
    SCLK = 1'b1;
    @(negedge CLK);
  endtask

  // Send one byte, check the strobe latency and payload, optionally probe a read
  // address across the write edge.
  task automatic send_byte(input logic [7:0] b, input logic dc,
                           input bit probe, input int probe_addr);
    int lat = 0;
    logic [7:0] old_v;
    logic [7:0] new_v;
    DC = dc;
    for (int i = 7; i >= 1; i--) send_bit(b[i]);
    @(negedge CLK);
    SCLK = 1'b0;
    SDIN = b[0];
    repeat (2) @(negedge CLK);
    old_v = fb_exp(probe_addr);
    model_byte(b, dc);
    new_v = fb_exp(probe_addr);
    SCLK = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(posedge CLK);
      #1;
      if (byte_valid === 1'b1 && lat == 0) begin
        lat = i;
        check("byte_data", byte_data, b);
        check("byte_is_data", byte_is_data, dc);
      end
      if (probe && i == 4) check("rd_old", fb_rd_data, old_v);
      if (probe && i == 5) check("rd_new", fb_rd_data, new_v);
    end
    check("latency", lat, 4);
    $display("[TB] byte 0x%02h dc=%0d -> data=0x%02h page=%0d col=0x%02h count=%0d",
             b, dc, byte_data, cur_page, cur_col, data_count);
  endtask

  task automatic read_check(input string tag, input int addr);
    @(negedge CLK);
    fb_rd_addr = ADDR_W'(addr);
    @(posedge CLK);
    #1;
    check(tag, fb_rd_data, fb_exp(addr));
  endtask

  task automatic check_state(input string pre);
    @(negedge CLK);
    check({pre, "_page"}, cur_page, m_page);
    check({pre, "_col"}, cur_col, m_col);
    check({pre, "_count"}, data_count, m_count);
    check({pre, "_ferr"}, frame_err, m_err);
    check({pre, "_pulses"}, pulse_cnt, m_pulses);
  endtask

  task automatic check_zero(input string pre);
    check({pre, "_valid"}, byte_valid, 0);
    check({pre, "_data"}, byte_data, 0);
    check({pre, "_isdata"}, byte_is_data, 0);
    check({pre, "_page"}, cur_page, 0);
    check({pre, "_col"}, cur_col, 0);
    check({pre, "_ferr"}, frame_err, 0);
    check({pre, "_count"}, data_count, 0);
    check({pre, "_rd"}, fb_rd_data, 0);
  endtask

  initial begin
    logic [7:0] b;
    logic       dc;
    RST = 1'b1; CS = 1'b1; SCLK = 1'b1; SDIN = 1'b0; DC = 1'b0;
    fb_rd_addr = '0;
    repeat (4) @(posedge CLK);
    #1;
    check_zero("reset");
    @(negedge CLK);
    RST = 1'b0;

    // Addressing and write
    CS = 1'b0;
    repeat (4) @(negedge CLK);
    send_byte(8'hB2, 1'b0, 1'b0, 0);
    send_byte(8'h05, 1'b0, 1'b0, 0);
    send_byte(8'h13, 1'b0, 1'b0, 0);
    send_byte(8'hA5, 1'b1, 1'b0, 0);
    check_state("addr");
    read_check("rd_309", 309);
    // Overwrite the same cell while reading it: old value first, then new.
    send_byte(8'h05, 1'b0, 1'b0, 0);
    send_byte(8'h13, 1'b0, 1'b0, 0);
    @(negedge CLK);
    fb_rd_addr = ADDR_W'(309);
    send_byte(8'h5A, 1'b1, 1'b1, 309);

    // Column wrap
    send_byte(8'hB1, 1'b0, 1'b0, 0);
    send_byte(8'h0F, 1'b0, 1'b0, 0);
    send_byte(8'h17, 1'b0, 1'b0, 0);
    send_byte(8'h11, 1'b1, 1'b0, 0);
    send_byte(8'h22, 1'b1, 1'b0, 0);
    check_state("wrap");
    read_check("rd_255", 255);
    read_check("rd_128", 128);

    // Argument skip, then confirm decoding resumes
    send_byte(8'h81, 1'b0, 1'b0, 0);
    send_byte(8'hB5, 1'b0, 1'b0, 0);
    send_byte(8'h21, 1'b0, 1'b0, 0);
    send_byte(8'hB3, 1'b0, 1'b0, 0);
    send_byte(8'h07, 1'b0, 1'b0, 0);
    check_state("skip");
    send_byte(8'hB3, 1'b0, 1'b0, 0);
    check_state("resume");
    // Data byte in the middle of an argument list aborts it
    send_byte(8'h81, 1'b0, 1'b0, 0);
    send_byte(8'h77, 1'b1, 1'b0, 0);
    send_byte(8'hB0, 1'b0, 1'b0, 0);
    check_state("abort");

    // Randomised byte stream
    for (int n = 0; n < 40; n++) begin
      dc = ($urandom_range(0, 4) < 2);
      case ($urandom_range(0, 7))
        0: b = 8'($urandom_range(0, 15));
        1: b = 8'($urandom_range(16, 23));
        2, 3: b = 8'($urandom_range('hB0, 'hB7));
        4, 5: b = arg_cmds[$urandom_range(0, 10)];
        default: b = 8'($urandom);
      endcase
      send_byte(b, dc, 1'b0, 0);
    end
    check_state("rand");
    for (int k = 0; k < 6; k++) begin
      read_check("rd_rand", wr_q[$urandom_range(0, wr_q.size() - 1)]);
    end

    // Framing error: 5 bits then CS high
    for (int i = 0; i < 5; i++) send_bit(i[0]);
    repeat (3) @(negedge CLK);
    CS = 1'b1;
    repeat (6) @(negedge CLK);
    m_err = 1;
    check_state("ferr");
    CS = 1'b0;
    repeat (4) @(negedge CLK);
    send_byte(8'h3C, 1'b0, 1'b0, 0);
    check_state("ferr_after");

    // Reset in the middle of a byte
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    @(negedge CLK);
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check_zero("midrst");
    @(negedge CLK);
    RST = 1'b0;
    m_page = 0; m_col = 0; m_count = 0; m_skip = 0; m_err = 0;
    repeat (4) @(negedge CLK);
    send_byte(8'hC3, 1'b0, 1'b0, 0);
    check_state("postrst");
    read_check("rd_keep", 309);

    // Data count saturation from a preset near the top
    force dut.count_reg = 16'hFFFD;
    repeat (2) @(negedge CLK);
    release dut.count_reg;
    m_count = 65533;
    for (int i = 0; i < 3; i++) begin
      send_byte(8'(8'h40 + i), 1'b1, 1'b0, 0);
      check("sat_count", data_count, m_count);
    end
    check_state("sat");
    read_check("rd_sat", wr_q[wr_q.size() - 1]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time limit so the run always terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not finish");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

endmodule
